vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_timeout.sv | 42 ++++
 rtl/vend_controller.sv | 182 ++++++++++++++++++
 tb/tb_vend_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending controller.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PAY      = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } state_e;

    localparam logic [7:0] PRICE_DEFAULT      = 8'd75;
    localparam int         TIMEOUT_DEFAULT    = 40;
    localparam logic [3:0] INIT_STOCK_DEFAULT = 4'd5;

    // Credit accumulation clamps at 255 instead of wrapping.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/vend_timeout.sv
// Idle-cycle counter for the PAY state; expired fires on the TIMEOUT-th idle cycle.
module vend_timeout #(
    parameter int TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] FULL = W'(TIMEOUT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear dominates, otherwise count idle cycles up to TIMEOUT.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != FULL)) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/vend_controller.sv
// Vending machine controller: selection, payment, dispense and change handshakes,
// with a 16-slot stock table.
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [7:0] PRICE      = PRICE_DEFAULT,
    parameter int         TIMEOUT    = TIMEOUT_DEFAULT,
    parameter logic [3:0] INIT_STOCK = INIT_STOCK_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_valid,
    input  logic [3:0] sel_index,
    input  logic       coin_valid,
    input  logic [7:0] coin_value,
    input  logic       cancel,
    input  logic       restock_valid,
    input  logic [3:0] restock_index,
    input  logic [3:0] restock_count,
    input  logic       dispense_done,
    input  logic       change_ready,
    output logic [2:0] state,
    output logic [7:0] credit,
    output logic       out_of_stock,
    output logic       dispense_valid,
    output logic [3:0] dispense_index,
    output logic       change_valid,
    output logic [7:0] change_amount
);

    state_e     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [3:0] slot_q, slot_d;
    logic       oos_q, oos_d;
    logic       dispense_valid_q, dispense_valid_d;
    logic [3:0] dispense_index_q, dispense_index_d;
    logic       change_valid_q, change_valid_d;
    logic [7:0] change_amount_q, change_amount_d;

    logic [3:0] stock_q [16];
    logic       stock_we_s;
    logic [3:0] stock_widx_s;
    logic [3:0] stock_wdata_s;

    logic       tmo_clear_s;
    logic       tmo_enable_s;
    logic       tmo_expired_s;
    logic [7:0] coin_sum_s;

    assign tmo_enable_s = (state_q == ST_PAY) && !coin_valid;
    assign tmo_clear_s  = (state_q != ST_PAY) || coin_valid;
    assign coin_sum_s   = sat_add(credit_q, coin_value);

    vend_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear_s),
        .enable  (tmo_enable_s),
        .expired (tmo_expired_s)
    );

    // Next-state, credit, stock write and handshake-output logic.
    always_comb begin
        state_d          = state_q;
        credit_d         = credit_q;
        slot_d           = slot_q;
        oos_d            = 1'b0;
        dispense_valid_d = 1'b0;
        dispense_index_d = dispense_index_q;
        change_valid_d   = 1'b0;
        change_amount_d  = change_amount_q;
        stock_we_s       = 1'b0;
        stock_widx_s     = 4'd0;
        stock_wdata_s    = 4'd0;

        case (state_q)
            ST_IDLE: begin
                if (restock_valid) begin
                    stock_we_s    = 1'b1;
                    stock_widx_s  = restock_index;
                    stock_wdata_s = restock_count;
                end else if (sel_valid) begin
                    if (stock_q[sel_index] != 4'd0) begin
                        slot_d  = sel_index;
                        state_d = ST_PAY;
                    end else begin
                        oos_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAY: begin
                if (coin_valid) begin
                    credit_d = coin_sum_s;
                end else begin
                    credit_d = credit_q;
                end
                // Cancel outranks both a completed payment and the timeout.
                if (cancel) begin
                    state_d = ST_REFUND;
                end else if (credit_d >= PRICE) begin
                    state_d = ST_DISPENSE;
                end else if (tmo_expired_s) begin
                    state_d = ST_REFUND;
                end else begin
                    state_d = ST_PAY;
                end
            end
            ST_DISPENSE: begin
                // An ack counts only once the request is actually on the wire.
                if (dispense_valid_q && dispense_done) begin
                    stock_we_s    = 1'b1;
                    stock_widx_s  = slot_q;
                    stock_wdata_s = stock_q[slot_q] - 4'd1;
                    credit_d      = credit_q - PRICE;
                    state_d       = (credit_d != 8'd0) ? ST_CHANGE : ST_IDLE;
                end else begin
                    dispense_valid_d = 1'b1;
                    dispense_index_d = slot_q;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                if (change_valid_q && change_ready) begin
                    credit_d = 8'd0;
                    state_d  = ST_IDLE;
                end else begin
                    change_valid_d  = 1'b1;
                    change_amount_d = credit_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            credit_q         <= 8'd0;
            slot_q           <= 4'd0;
            oos_q            <= 1'b0;
            dispense_valid_q <= 1'b0;
            dispense_index_q <= 4'd0;
            change_valid_q   <= 1'b0;
            change_amount_q  <= 8'd0;
        end else begin
            state_q          <= state_d;
            credit_q         <= credit_d;
            slot_q           <= slot_d;
            oos_q            <= oos_d;
            dispense_valid_q <= dispense_valid_d;
            dispense_index_q <= dispense_index_d;
            change_valid_q   <= change_valid_d;
            change_amount_q  <= change_amount_d;
        end
    end

    // Per-slot stock table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                stock_q[i] <= INIT_STOCK;
            end
        end else if (stock_we_s) begin
            stock_q[stock_widx_s] <= stock_wdata_s;
        end
    end

    assign state          = state_q;
    assign credit         = credit_q;
    assign out_of_stock   = oos_q;
    assign dispense_valid = dispense_valid_q;
    assign dispense_index = dispense_index_q;
    assign change_valid   = change_valid_q;
    assign change_amount  = change_amount_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with a cycle-based behavioural model.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_valid = 1'b0;
    logic [3:0] sel_index = 4'd0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = 8'd0;
    logic       cancel = 1'b0;
    logic       restock_valid = 1'b0;
    logic [3:0] restock_index = 4'd0;
    logic [3:0] restock_count = 4'd0;
    logic       dispense_done = 1'b0;
    logic       change_ready = 1'b0;
    logic [2:0] state;
    logic [7:0] credit;
    logic       out_of_stock;
    logic       dispense_valid;
    logic [3:0] dispense_index;
    logic       change_valid;
    logic [7:0] change_amount;

    int checks = 0;
    int failures = 0;

    vend_controller dut (
        .clk            (clk),
        .rst            (rst),
        .sel_valid      (sel_valid),
        .sel_index      (sel_index),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .cancel         (cancel),
        .restock_valid  (restock_valid),
        .restock_index  (restock_index),
        .restock_count  (restock_count),
        .dispense_done  (dispense_done),
        .change_ready   (change_ready),
        .state          (state),
        .credit         (credit),
        .out_of_stock   (out_of_stock),
        .dispense_valid (dispense_valid),
        .dispense_index (dispense_index),
        .change_valid   (change_valid),
        .change_amount  (change_amount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0=IDLE 1=PAY 2=DISPENSE 3=CHANGE 4=REFUND.
    int m_state, m_credit, m_slot, m_idle, m_di, m_ca;
    int m_stock [16];
    bit m_oos, m_dv, m_cv;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_credit = 0; m_slot = 0; m_idle = 0;
            m_oos = 0; m_dv = 0; m_di = 0; m_cv = 0; m_ca = 0;
            foreach (m_stock[k]) m_stock[k] = 5;
            chk_en = 1'b1;
        end else begin
            m_oos = 0;
            case (m_state)
                0: begin
                    if (restock_valid) m_stock[restock_index] = restock_count;
                    else if (sel_valid) begin
                        if (m_stock[sel_index] > 0) begin
                            m_slot = sel_index; m_idle = 0; m_state = 1;
                        end else m_oos = 1;
                    end
                end
                1: begin
                    if (coin_valid) begin
                        m_credit = m_credit + coin_value;
                        if (m_credit > 255) m_credit = 255;
                        m_idle = 0;
                    end else m_idle++;
                    if (cancel) m_state = 4;
                    else if (m_credit >= 75) m_state = 2;
                    else if (m_idle >= 40) m_state = 4;
                end
                2: begin
                    if (m_dv && dispense_done) begin
                        m_stock[m_slot]--; m_credit -= 75; m_dv = 0;
                        m_state = (m_credit != 0) ? 3 : 0;
                    end else begin
                        m_dv = 1; m_di = m_slot;
                    end
                end
                default: begin
                    if (m_cv && change_ready) begin
                        m_credit = 0; m_cv = 0; m_state = 0;
                    end else begin
                        m_cv = 1; m_ca = m_credit;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", int'(state), m_state);
            check("credit", int'(credit), m_credit);
            check("out_of_stock", int'(out_of_stock), int'(m_oos));
            check("dispense_valid", int'(dispense_valid), int'(m_dv));
            check("dispense_index", int'(dispense_index), m_di);
            check("change_valid", int'(change_valid), int'(m_cv));
            check("change_amount", int'(change_amount), m_ca);
        end
    end

    task automatic step(input logic sv, input logic [3:0] si, input logic cv, input logic [7:0] cval,
                        input logic cn, input logic rv, input logic [3:0] ri, input logic [3:0] rc,
                        input logic dd, input logic cr);
        sel_valid = sv; sel_index = si; coin_valid = cv; coin_value = cval; cancel = cn;
        restock_valid = rv; restock_index = ri; restock_count = rc;
        dispense_done = dd; change_ready = cr;
        @(negedge clk);
        sel_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0; restock_valid = 1'b0;
        dispense_done = 1'b0; change_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 0, 8'd0, 0, 0, 4'd0, 4'd0, 0, 0);
    endtask
    task automatic do_sel(input logic [3:0] s);  step(1, s, 0, 8'd0, 0, 0, 4'd0, 4'd0, 0, 0); endtask
    task automatic do_coin(input logic [7:0] v); step(0, 4'd0, 1, v, 0, 0, 4'd0, 4'd0, 0, 0); endtask
    task automatic do_cancel();                  step(0, 4'd0, 0, 8'd0, 1, 0, 4'd0, 4'd0, 0, 0); endtask
    task automatic do_done();                    step(0, 4'd0, 0, 8'd0, 0, 0, 4'd0, 4'd0, 1, 0); endtask
    task automatic do_ready();                   step(0, 4'd0, 0, 8'd0, 0, 0, 4'd0, 4'd0, 0, 1); endtask

    task automatic wait_dv();
        int n = 0;
        while (dispense_valid !== 1'b1 && n < 20) begin idle(1); n++; end
        check("dispense_valid_wait", int'(dispense_valid), 1);
    endtask
    task automatic wait_cv();
        int n = 0;
        while (change_valid !== 1'b1 && n < 20) begin idle(1); n++; end
        check("change_valid_wait", int'(change_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_state", int'(state), 0);
        check("reset_credit", int'(credit), 0);

        // Exact payment on slot 3
        do_sel(4'd3);
        check("sel3_pay", int'(state), 1);
        do_coin(8'd25); do_coin(8'd25);
        check("credit_50", int'(credit), 50);
        do_coin(8'd25);
        check("enter_dispense", int'(state), 2);
        check("dv_not_yet", int'(dispense_valid), 0);
        idle(1);
        check("dv_asserted", int'(dispense_valid), 1);
        check("dispense_index_3", int'(dispense_index), 3);
        do_cancel();
        check("cancel_ignored", int'(state), 2);
        do_done();
        check("exact_idle", int'(state), 0);
        check("exact_credit0", int'(credit), 0);
        check("exact_no_change", int'(change_valid), 0);
        check("model_stock3", m_stock[3], 4);
        idle(2);

        // Stray acks and coins in IDLE
        step(0, 4'd0, 1, 8'd50, 0, 0, 4'd0, 4'd0, 1, 1);
        check("idle_coin_ignored", int'(credit), 0);

        // Overpay on slot 1 -> change of 25
        do_sel(4'd1);
        do_coin(8'd50); do_coin(8'd50);
        check("credit_100", int'(credit), 100);
        wait_dv();
        do_done();
        check("enter_change", int'(state), 3);
        wait_cv();
        check("change_25", int'(change_amount), 25);
        idle(2);
        do_ready();
        check("change_idle", int'(state), 0);

        // Empty slot selection
        step(0, 4'd0, 0, 8'd0, 0, 1, 4'd7, 4'd0, 0, 0);
        do_sel(4'd7);
        check("oos_pulse", int'(out_of_stock), 1);
        check("oos_state", int'(state), 0);
        idle(1);
        check("oos_cleared", int'(out_of_stock), 0);
        step(1, 4'd2, 0, 8'd0, 0, 1, 4'd2, 4'd9, 0, 0);
        check("restock_wins", int'(state), 0);

        // Timeout refund
        do_sel(4'd0);
        do_coin(8'd25);
        idle(39);
        check("still_pay_39", int'(state), 1);
        idle(1);
        check("timeout_refund", int'(state), 4);
        wait_cv();
        check("refund_25", int'(change_amount), 25);
        do_ready();

        // Cancel with coin in same cycle, credit reaching price
        do_sel(4'd4);
        do_coin(8'd50);
        step(0, 4'd0, 1, 8'd25, 1, 0, 4'd0, 4'd0, 0, 0);
        check("cancel_refund", int'(state), 4);
        check("cancel_credit75", int'(credit), 75);
        wait_cv();
        check("refund_75", int'(change_amount), 75);
        check("no_dispense", int'(dispense_valid), 0);
        do_ready();

        // Saturation, restock ignored outside IDLE
        do_sel(4'd6);
        step(0, 4'd0, 1, 8'd50, 0, 1, 4'd6, 4'd0, 0, 0);
        step(0, 4'd0, 1, 8'd250, 1, 0, 4'd0, 4'd0, 0, 0);
        check("saturate_255", int'(credit), 255);
        wait_cv();
        check("refund_255", int'(change_amount), 255);
        do_ready();
        do_sel(4'd6);
        check("slot6_kept", int'(state), 1);
        do_cancel();
        wait_cv();
        do_ready();

        // Reset during dispense
        do_sel(4'd3);
        do_coin(8'd75);
        wait_dv();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_state", int'(state), 0);
        check("rst_dv", int'(dispense_valid), 0);
        check("rst_credit", int'(credit), 0);
        begin
            int all5 = 1;
            foreach (m_stock[k]) if (m_stock[k] != 5) all5 = 0;
            check("model_stock_all5", all5, 1);
        end
        do_sel(4'd7);
        check("slot7_restored", int'(state), 1);
        do_cancel();
        wait_cv();
        do_ready();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
